// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for lock, qualifies stability, then releases user reset.
// Define PLL_RST_CTRL_STATUS_EN to add the lock_loss_cnt / retry_cnt status counters.
module pll_rst_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       user_rst_n,
  output logic       ready,
  output logic [1:0] state
`ifdef PLL_RST_CTRL_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
`endif
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    READY     = 2'd3
  } state_t;

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             locked_m;
  logic             locked_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pll_rst_d;
  logic             ready_d;

  // State register, synchronizer and registered outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      locked_m   <= 1'b0;
      locked_s   <= 1'b0;
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      pll_rst    <= 1'b1;
      user_rst_n <= 1'b0;
      ready      <= 1'b0;
    end else begin
      locked_m   <= locked;
      locked_s   <= locked_m;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rst    <= pll_rst_d;
      user_rst_n <= ready_d;
      ready      <= ready_d;
    end
  end

  // Next-state logic; soft_reset overrides every other transition.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (soft_reset) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        READY: begin
          if (!locked_s) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: outputs decode the next state and are then registered, so they change on the
  // same edge as state with no input-to-output combinational path.
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL);
    ready_d   = (state_d == READY);
  end

  assign state = state_q;

`ifdef PLL_RST_CTRL_STATUS_EN
  logic loss_evt;
  logic retry_evt;

  assign loss_evt  = !soft_reset && (state_q == READY) && !locked_s;
  assign retry_evt = !soft_reset && (state_q == WAIT_LOCK) && !locked_s && (cnt_q == LOCK_LAST);

  // Saturating event counters, cleared only by rst_n.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
      retry_cnt     <= 8'd0;
    end else begin
      if (loss_evt && (lock_loss_cnt != 8'hFF)) lock_loss_cnt <= lock_loss_cnt + 8'd1;
      if (retry_evt && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Scoreboard bench for pll_rst_ctrl: stimulus queues expected state changes with dwell times,
// a negedge monitor pops and compares on every output change.
module tb_pll_rst_ctrl;

  localparam logic [1:0] S_RST  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_STB  = 2'd2;
  localparam logic [1:0] S_RDY  = 2'd3;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       soft_reset;
  logic       pll_rst;
  logic       user_rst_n;
  logic       ready;
  logic [1:0] state;
`ifdef PLL_RST_CTRL_STATUS_EN
  logic [7:0] lock_loss_cnt;
  logic [7:0] retry_cnt;
`endif

  pll_rst_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .soft_reset   (soft_reset),
    .pll_rst      (pll_rst),
    .user_rst_n   (user_rst_n),
    .ready        (ready),
    .state        (state)
`ifdef PLL_RST_CTRL_STATUS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [1:0] st;
    logic       pr;
    logic       rd;
    logic       ur;
    int         dwell;
    int         ll;
    int         rt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   e_ll  = 0;
  int   e_rt  = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs follow from the state: pll_rst only in RESET_PLL, ready/user_rst_n only in READY.
  function automatic void push(input logic [1:0] st, input int dwell);
    exp_t e;
    e.st    = st;
    e.pr    = (st == S_RST);
    e.rd    = (st == S_RDY);
    e.ur    = (st == S_RDY);
    e.dwell = dwell;
    e.ll    = e_ll;
    e.rt    = e_rt;
    sb_q.push_back(e);
  endfunction

  // Monitor: dwell is the number of negedge samples the previous output pattern lasted.
  int         ncyc = 0;
  int         last = 0;
  logic [4:0] snap;
  logic [4:0] prev;
  always @(negedge refclk) begin
    exp_t e;
    ncyc++;
    snap = {state, pll_rst, ready, user_rst_n};
    if (!mon_en) begin
      prev = snap;
      last = ncyc;
    end else if (snap !== prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change actual_state=%0d at %0t", state, $time);
      end else begin
        e = sb_q.pop_front();
        check("state", 32'(state), 32'(e.st));
        check("outs", 32'({pll_rst, ready, user_rst_n}), 32'({e.pr, e.rd, e.ur}));
        check("dwell", 32'(ncyc - last), 32'(e.dwell));
`ifdef PLL_RST_CTRL_STATUS_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.ll));
        check("retry_cnt", 32'(retry_cnt), 32'(e.rt));
`endif
      end
      prev = snap;
      last = ncyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
    #1;
  endtask

  task automatic drain();
    int budget = 400;
    while (sb_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic reset_checks();
    check("rst_state", 32'(state), 32'(S_RST));
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_user_rst_n", 32'(user_rst_n), 32'd0);
`ifdef PLL_RST_CTRL_STATUS_EN
    check("rst_lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    check("rst_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    locked     = 1'b0;
    soft_reset = 1'b0;
    tick(3);
    reset_checks();

    // Power-up: 4-cycle pll_rst, lock 10 cycles into WAIT_LOCK, 2 sync + 1 decision edge, 8 stable.
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(S_WAIT, 4);
    drain();
    tick(10);
    locked = 1'b1;
    push(S_STB, 13);
    push(S_RDY, 8);
    drain();

    // Lock loss from READY, then three lock timeouts with 4-cycle retry pulses.
    tick(3);
    locked = 1'b0;
    e_ll   = 1;
    push(S_RST, 6);
    push(S_WAIT, 4);
    for (int i = 1; i <= 3; i++) begin
      e_rt = i;
      push(S_RST, 20);
      push(S_WAIT, 4);
    end
    drain();

    // Lock glitch at stable count 5: back to WAIT_LOCK without a PLL reset, then 8 fresh cycles.
    locked = 1'b1;
    push(S_STB, 3);
    drain();
    push(S_WAIT, 6);
    push(S_STB, 3);
    push(S_RDY, 8);
    tick(3);
    locked = 1'b0;
    tick(3);
    locked = 1'b1;
    drain();

    // soft_reset on the edge where locked_s falls in READY: not a counted loss.
    push(S_RST, 4);
    push(S_WAIT, 4);
    tick(1);
    locked = 1'b0;
    tick(2);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    drain();

    // soft_reset held for 10 cycles keeps RESET_PLL.
    push(S_RST, 3);
    push(S_WAIT, 13);
    tick(2);
    soft_reset = 1'b1;
    tick(10);
    soft_reset = 1'b0;
    drain();

    // soft_reset coinciding with a lock timeout: not a counted retry.
    push(S_RST, 20);
    push(S_WAIT, 4);
    tick(19);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    drain();

    // One-cycle rst_n during WAIT_LOCK restarts the sequence and clears the status counters.
    e_ll = 0;
    e_rt = 0;
    push(S_RST, 6);
    push(S_WAIT, 4);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    reset_checks();
    rst_n = 1'b1;
    drain();

    // 300 lock losses: lock_loss_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      push(S_STB, 3);
      push(S_RDY, 8);
      drain();
      locked = 1'b0;
      if (e_ll < 255) e_ll++;
      push(S_RST, 3);
      push(S_WAIT, 4);
      drain();
    end
`ifdef PLL_RST_CTRL_STATUS_EN
    check("lock_loss_sat", 32'(lock_loss_cnt), 32'd255);
`endif
    check("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
